// File: rtl/vga_rect_writer.sv
// Bus initiator that fills a clamped rectangle of the 160x120 frame buffer with one pixel value.
// Optional macro VGA_RECT_SKIPX_EN: column-major traversal, X written only when the held column changes.
module vga_rect_writer #(
    parameter int          HOR_RES     = 160,
    parameter int          VERT_RES    = 120,
    parameter logic [7:0]  X_ADDR_CODE = 8'hB1,
    parameter logic [7:0]  Y_ADDR_CODE = 8'hB0,
    parameter logic [7:0]  IDLE_ADDR   = 8'hFF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] X0,
    input  logic [7:0] X1,
    input  logic [6:0] Y0,
    input  logic [6:0] Y1,
    input  logic       PIXEL,
    input  logic       BUS_GNT,
    output logic       BUS_REQ,
    output logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_OE,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [7:0] X_MAX = 8'(HOR_RES - 1);
    localparam logic [6:0] Y_MAX = 7'(VERT_RES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_SET_X = 3'd2,
        ST_SET_Y = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    function automatic logic [7:0] clamp_x(input logic [7:0] v);
        clamp_x = (v > X_MAX) ? X_MAX : v;
    endfunction

    function automatic logic [6:0] clamp_y(input logic [6:0] v);
        clamp_y = (v > Y_MAX) ? Y_MAX : v;
    endfunction

    state_t     state_r;
    logic [7:0] x_r, xl_r, xh_r;
    logic [6:0] y_r, yl_r, yh_r;
    logic       pix_r;

    logic [7:0] xl_s, xh_s, x_next_s;
    logic [6:0] yl_s, yh_s, y_next_s;
    logic       last_s;
`ifdef VGA_RECT_SKIPX_EN
    logic       new_col_s;
`endif

    // Ordered and clamped corners, ready to latch on START
    always_comb begin
        xl_s = clamp_x((X0 < X1) ? X0 : X1);
        xh_s = clamp_x((X0 < X1) ? X1 : X0);
        yl_s = clamp_y((Y0 < Y1) ? Y0 : Y1);
        yh_s = clamp_y((Y0 < Y1) ? Y1 : Y0);
    end

    // Next pixel position; compares are against latched bounds so counters never wrap
    always_comb begin
        x_next_s = x_r;
        y_next_s = y_r;
        last_s   = (x_r == xh_r) && (y_r == yh_r);
`ifdef VGA_RECT_SKIPX_EN
        new_col_s = 1'b0;
        if (y_r == yh_r) begin
            y_next_s  = yl_r;
            x_next_s  = x_r + 8'd1;
            new_col_s = 1'b1;
        end else begin
            y_next_s  = y_r + 7'd1;
        end
`else
        if (x_r == xh_r) begin
            x_next_s = xl_r;
            y_next_s = y_r + 7'd1;
        end else begin
            x_next_s = x_r + 8'd1;
        end
`endif
    end

    // Sequencer; outputs are registered alongside the state they belong to
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            BUS_REQ      <= 1'b0;
            BUS_ADDR     <= IDLE_ADDR;
            BUS_DATA_OUT <= 8'd0;
            BUS_DATA_OE  <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            x_r          <= 8'd0;
            xl_r         <= 8'd0;
            xh_r         <= 8'd0;
            y_r          <= 7'd0;
            yl_r         <= 7'd0;
            yh_r         <= 7'd0;
            pix_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        xl_r    <= xl_s;
                        xh_r    <= xh_s;
                        yl_r    <= yl_s;
                        yh_r    <= yh_s;
                        x_r     <= xl_s;
                        y_r     <= yl_s;
                        pix_r   <= PIXEL;
                        BUSY    <= 1'b1;
                        BUS_REQ <= 1'b1;
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (BUS_GNT) begin
                        BUS_ADDR     <= X_ADDR_CODE;
                        BUS_DATA_OUT <= x_r;
                        BUS_DATA_OE  <= 1'b1;
                        state_r      <= ST_SET_X;
                    end else begin
                        state_r      <= ST_REQ;
                    end
                end
                ST_SET_X: begin
                    BUS_ADDR     <= Y_ADDR_CODE;
                    BUS_DATA_OUT <= {y_r, pix_r};
                    BUS_DATA_OE  <= 1'b1;
                    state_r      <= ST_SET_Y;
                end
                ST_SET_Y: begin
                    if (last_s) begin
                        BUS_REQ      <= 1'b0;
                        BUS_ADDR     <= IDLE_ADDR;
                        BUS_DATA_OUT <= 8'd0;
                        BUS_DATA_OE  <= 1'b0;
                        BUSY         <= 1'b0;
                        DONE         <= 1'b1;
                        state_r      <= ST_FIN;
                    end else begin
                        x_r <= x_next_s;
                        y_r <= y_next_s;
                        if (!BUS_GNT) begin
                            BUS_ADDR     <= IDLE_ADDR;
                            BUS_DATA_OUT <= 8'd0;
                            BUS_DATA_OE  <= 1'b0;
                            state_r      <= ST_REQ;
`ifdef VGA_RECT_SKIPX_EN
                        end else if (!new_col_s) begin
                            // Peripheral still holds X: go straight to the next Y write
                            BUS_ADDR     <= Y_ADDR_CODE;
                            BUS_DATA_OUT <= {y_next_s, pix_r};
                            BUS_DATA_OE  <= 1'b1;
                            state_r      <= ST_SET_Y;
`endif
                        end else begin
                            BUS_ADDR     <= X_ADDR_CODE;
                            BUS_DATA_OUT <= x_next_s;
                            BUS_DATA_OE  <= 1'b1;
                            state_r      <= ST_SET_X;
                        end
                    end
                end
                ST_FIN: begin
                    DONE    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    BUS_REQ      <= 1'b0;
                    BUS_ADDR     <= IDLE_ADDR;
                    BUS_DATA_OUT <= 8'd0;
                    BUS_DATA_OE  <= 1'b0;
                    BUSY         <= 1'b0;
                    DONE         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
